// File: rtl/glb_rd_arb.sv
// rtl/glb_rd_arb.sv - GLB read-port arbiter with in-order response routing to requesters
// Optional build macro GLB_RD_ARB_PRIO_EN: requester 0 wins whenever valid, others round-robin.
module glb_rd_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Clr,
    input  logic [NUM_REQ-1:0]            REQ_AddrVld,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_Addr,
    output logic [NUM_REQ-1:0]            REQ_AddrRdy,
    output logic [DATA_WIDTH-1:0]         REQ_Data,
    output logic [NUM_REQ-1:0]            REQ_DataVld,
    input  logic [NUM_REQ-1:0]            REQ_DataRdy,
    output logic [ADDR_WIDTH-1:0]         GLB_Addr,
    output logic                          GLB_AddrVld,
    input  logic                          GLB_AddrRdy,
    input  logic [DATA_WIDTH-1:0]         GLB_Data,
    input  logic                          GLB_DataVld,
    output logic                          GLB_DataRdy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef enum logic {ARB, HOLD} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] holdGnt;
    logic [IW-1:0] arbGnt;
    logic          arbFound;
    logic [IW-1:0] gnt;
    logic [IW-1:0] gntNext;
    logic          notFull;
    logic          push;
    logic          pop;
    logic [IW-1:0] idFifo [FIFO_DEPTH];
    logic [FW-1:0] wrPtr;
    logic [FW-1:0] rdPtr;
    logic [FW:0]   cnt;
    logic [IW-1:0] head;

    // First valid requester at or after ptr, wrapping; requester 0 is skipped here in the priority build
    always_comb begin
        logic [IW:0] idx;
        arbGnt   = '0;
        arbFound = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NUM_REQ))
                idx = idx - (IW+1)'(NUM_REQ);
`ifdef GLB_RD_ARB_PRIO_EN
            if (!arbFound && (idx != '0) && REQ_AddrVld[idx[IW-1:0]]) begin
`else
            if (!arbFound && REQ_AddrVld[idx[IW-1:0]]) begin
`endif
                arbGnt   = idx[IW-1:0];
                arbFound = 1'b1;
            end
        end
`ifdef GLB_RD_ARB_PRIO_EN
        if (REQ_AddrVld[0]) begin
            arbGnt   = '0;
            arbFound = 1'b1;
        end
`endif
    end

    assign gnt         = (state == HOLD) ? holdGnt : arbGnt;
    assign gntNext     = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    assign notFull     = (cnt < (FW+1)'(FIFO_DEPTH));
    assign GLB_AddrVld = ((state == HOLD) | arbFound) & notFull & ~Clr;
    assign GLB_Addr    = REQ_Addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    assign push        = GLB_AddrVld & GLB_AddrRdy;
    assign REQ_AddrRdy = push ? (NUM_REQ'(1) << gnt) : '0;

    // Return path: data is routed to whoever owns the oldest outstanding read
    assign head        = idFifo[rdPtr];
    assign GLB_DataRdy = (cnt == '0) ? 1'b1 : REQ_DataRdy[head];
    assign pop         = GLB_DataVld & GLB_DataRdy & (cnt != '0);
    assign REQ_Data    = GLB_Data;
    assign REQ_DataVld = (GLB_DataVld && (cnt != '0)) ? (NUM_REQ'(1) << head) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB;
            ptr     <= '0;
            holdGnt <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            cnt     <= '0;
        end else if (Clr) begin
            state   <= ARB;
            ptr     <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            cnt     <= '0;
        end else begin
            if (push) begin
                state <= ARB;
                ptr   <= gntNext;
                wrPtr <= wrPtr + 1'b1;
            end else if (GLB_AddrVld) begin
                state   <= HOLD;
                holdGnt <= gnt;
            end
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            idFifo[wrPtr] <= gnt;
    end
endmodule

// File: tb/tb_glb_rd_arb.sv
// tb/tb_glb_rd_arb.sv - scoreboard bench for glb_rd_arb with a simple GLB memory model
module tb_glb_rd_arb;
    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 256;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Clr;
    logic [NR-1:0]    REQ_AddrVld;
    logic [NR*AW-1:0] REQ_Addr;
    logic [NR-1:0]    REQ_AddrRdy;
    logic [DW-1:0]    REQ_Data;
    logic [NR-1:0]    REQ_DataVld;
    logic [NR-1:0]    REQ_DataRdy;
    logic [AW-1:0]    GLB_Addr;
    logic             GLB_AddrVld;
    logic             GLB_AddrRdy;
    logic [DW-1:0]    GLB_Data;
    logic             GLB_DataVld;
    logic             GLB_DataRdy;

    glb_rd_arb dut (
        .clk(clk), .rst_n(rst_n), .Clr(Clr),
        .REQ_AddrVld(REQ_AddrVld), .REQ_Addr(REQ_Addr), .REQ_AddrRdy(REQ_AddrRdy),
        .REQ_Data(REQ_Data), .REQ_DataVld(REQ_DataVld), .REQ_DataRdy(REQ_DataRdy),
        .GLB_Addr(GLB_Addr), .GLB_AddrVld(GLB_AddrVld), .GLB_AddrRdy(GLB_AddrRdy),
        .GLB_Data(GLB_Data), .GLB_DataVld(GLB_DataVld), .GLB_DataRdy(GLB_DataRdy)
    );

    always #5 clk = ~clk;

    int            nTests = 0;
    int            nFail  = 0;
    int            cyc    = 0;
    int            accCount = 0;
    int            glbLat = 2;
    logic          glbStop = 1'b0;
    int            gntQ [$];
    exp_t          dataQ [$];
    ret_t          retQ [$];
    logic [AW-1:0] reqAddr [NR];
    int            reqLeft [NR];
    logic          sAddrVld;
    logic [AW-1:0] sAddr;
    logic [NR-1:0] sDataVld;
    logic          sDataRdy;
    logic          sAcc;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++)
            d[k*32 +: 32] = {a, 6'(k), 16'hBEEF};
        return d;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            REQ_AddrVld[i]        = (reqLeft[i] > 0);
            REQ_Addr[i*AW +: AW]  = reqAddr[i];
        end
        if (retQ.size() != 0 && !glbStop && cyc >= retQ[0].due) begin
            GLB_DataVld = 1'b1;
            GLB_Data    = retQ[0].data;
        end else begin
            GLB_DataVld = 1'b0;
            GLB_Data    = '0;
        end
    endtask

    task automatic monitor();
        logic [NR-1:0] expRdy;
        logic [NR-1:0] expVld;
        logic          expGlbRdy;
        exp_t          e;
        ret_t          r;
        sAddrVld = GLB_AddrVld;
        sAddr    = GLB_Addr;
        sDataVld = REQ_DataVld;
        sDataRdy = GLB_DataRdy;
        sAcc     = 1'b0;
        if (GLB_AddrVld) begin
            check("gnt_expected", gntQ.size() != 0, 1'b1);
            if (gntQ.size() != 0) begin
                int g = gntQ[0];
                expRdy = GLB_AddrRdy ? (NR'(1) << g) : '0;
                check("glb_addr", GLB_Addr, reqAddr[g]);
                check("addr_rdy", REQ_AddrRdy, expRdy);
                if (GLB_AddrRdy) begin
                    void'(gntQ.pop_front());
                    e.id   = 2'(g);
                    e.data = memWord(reqAddr[g]);
                    dataQ.push_back(e);
                    r.data = memWord(GLB_Addr);
                    r.due  = cyc + glbLat;
                    retQ.push_back(r);
                    reqAddr[g] = reqAddr[g] + 1'b1;
                    reqLeft[g]--;
                    accCount++;
                    sAcc = 1'b1;
                end
            end
        end else begin
            expRdy = '0;
            check("addr_rdy_idle", REQ_AddrRdy, expRdy);
        end
        expVld    = '0;
        expGlbRdy = 1'b1;
        if (GLB_DataVld && dataQ.size() != 0) begin
            expVld    = NR'(1) << dataQ[0].id;
            expGlbRdy = REQ_DataRdy[dataQ[0].id];
        end
        check("data_vld", REQ_DataVld, expVld);
        if (GLB_DataVld) begin
            check("glb_data_rdy", GLB_DataRdy, expGlbRdy);
            if (expGlbRdy) begin
                if (dataQ.size() != 0) begin
                    check("req_data", REQ_Data, dataQ[0].data);
                    void'(dataQ.pop_front());
                end
                void'(retQ.pop_front());
            end
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((retQ.size() + gntQ.size() + dataQ.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        check(tag, retQ.size() + gntQ.size() + dataQ.size(), 0);
    endtask

    task automatic waitGrants(input string tag);
        int n = 0;
        while (gntQ.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(tag, gntQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        for (int i = 0; i < NR; i++) begin
            reqAddr[i] = AW'(i * 64);
            reqLeft[i] = 0;
        end
        rst_n       = 1'b0;
        Clr         = 1'b0;
        REQ_AddrVld = '0;
        REQ_Addr    = '0;
        REQ_DataRdy = '0;
        GLB_AddrRdy = 1'b1;
        GLB_Data    = '1;
        GLB_DataVld = 1'b1;
        @(negedge clk);
        check("rst_glb_avld", GLB_AddrVld, 1'b0);
        check("rst_addr_rdy", REQ_AddrRdy, '0);
        check("rst_data_vld", REQ_DataVld, '0);
        check("rst_glb_drdy", GLB_DataRdy, 1'b1);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        REQ_DataRdy = '1;

        // All four requesters, two reads each: strict rotation, one acceptance per cycle
        for (int i = 0; i < NR; i++) reqLeft[i] = 2;
        for (int k = 0; k < 8; k++) gntQ.push_back(k % NR);
        acc0 = accCount;
        repeat (8) tick();
        check("b2b_accepts", accCount - acc0, 8);
        drain("drain_rr");

        // Stall with requester 2 granted; requester 0 arrives mid-stall and must wait
        GLB_AddrRdy = 1'b0;
        reqAddr[2]  = 10'h055;
        reqLeft[2]  = 1;
        gntQ.push_back(2);
        gntQ.push_back(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_addr", sAddr, 10'h055);
            check("hold_avld", sAddrVld, 1'b1);
            if (i == 0) begin
                reqAddr[0] = 10'h0AA;
                reqLeft[0] = 1;
            end
        end
        GLB_AddrRdy = 1'b1;
        tick();
        check("hold_release", sAcc, 1'b1);
        tick();
        check("after_hold_addr", sAddr, 10'h0AA);
        drain("drain_hold");

        // GLB silent: only FIFO_DEPTH reads in flight, one returned beat frees one slot
        glbStop    = 1'b1;
        reqLeft[1] = 6;
        repeat (6) gntQ.push_back(1);
        acc0 = accCount;
        repeat (8) tick();
        check("full_accepts", accCount - acc0, 4);
        check("full_avld", sAddrVld, 1'b0);
        glbStop = 1'b0;
        tick();
        glbStop = 1'b1;
        check("full_pop_avld", sAddrVld, 1'b0);
        tick();
        check("refill_acc", sAcc, 1'b1);
        check("refill_count", accCount - acc0, 5);
        glbStop = 1'b0;
        drain("drain_full");

        // Head requester back-pressures the return path
        glbStop    = 1'b1;
        reqLeft[3] = 1;
        reqLeft[0] = 1;
        gntQ.push_back(3);
        gntQ.push_back(0);
        waitGrants("bp_grants");
        REQ_DataRdy = 4'b0111;
        glbStop     = 1'b0;
        repeat (5) begin
            tick();
            check("bp_glb_rdy", sDataRdy, 1'b0);
            check("bp_data_vld", sDataVld, 4'b1000);
        end
        REQ_DataRdy = '1;
        drain("drain_bp");

        // Clr with three reads outstanding: stale beats discarded, arbitration restarts at 0
        glbStop    = 1'b1;
        reqLeft[1] = 1;
        reqLeft[2] = 2;
        gntQ.push_back(1);
        gntQ.push_back(2);
        gntQ.push_back(2);
        waitGrants("clr_grants");
        GLB_AddrRdy = 1'b0;
        Clr         = 1'b1;
        reqAddr[0]  = 10'h123;
        reqAddr[3]  = 10'h321;
        reqLeft[0]  = 1;
        reqLeft[3]  = 1;
        tick();
        check("clr_no_issue", sAddrVld, 1'b0);
        Clr = 1'b0;
        dataQ.delete();
        gntQ.push_back(0);
        gntQ.push_back(3);
        glbStop = 1'b0;
        tick();
        check("clr_first_gnt", sAddr, 10'h123);
        for (int n = 0; n < 20 && retQ.size() != 0; n++) tick();
        check("clr_stale_gone", retQ.size(), 0);
        GLB_AddrRdy = 1'b1;
        drain("drain_clr");

        // Reset in the middle of outstanding reads
        glbStop    = 1'b1;
        reqLeft[1] = 2;
        gntQ.push_back(1);
        gntQ.push_back(1);
        waitGrants("rst_grants");
        rst_n = 1'b0;
        dataQ.delete();
        tick();
        check("rst_mid_drdy", sDataRdy, 1'b1);
        rst_n   = 1'b1;
        glbStop = 1'b0;
        drain("drain_rst");

        // Requesters 0 and 1 continuously valid
        reqLeft[0] = 4;
        reqLeft[1] = 4;
`ifdef GLB_RD_ARB_PRIO_EN
        repeat (4) gntQ.push_back(0);
        repeat (4) gntQ.push_back(1);
`else
        repeat (4) begin
            gntQ.push_back(0);
            gntQ.push_back(1);
        end
`endif
        drain("drain_prio");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
